// File: rtl/fir_coeff_loader.sv
// fir_coeff_loader: streams NUM_TAPS coefficients into memory at addresses 0..NUM_TAPS-1 with a done pulse and running checksum.
module fir_coeff_loader #(
  parameter int NUM_TAPS = 11,
  parameter int COEF_W   = 16,
  parameter int ADDR_W   = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic              abort_i,
  input  logic              s_valid_i,
  input  logic [COEF_W-1:0] s_data_i,
  output logic              s_ready_o,
  output logic              we_o,
  output logic [ADDR_W-1:0] waddr_o,
  output logic [COEF_W-1:0] wdata_o,
  output logic              busy_o,
  output logic              done_o,
  output logic [COEF_W-1:0] checksum_o
);
  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_e;
  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d, waddr_q, waddr_d;
  logic [COEF_W-1:0]   sum_q, sum_d, wdata_q, wdata_d;
  logic                we_q, we_d, done_q, done_d;
  logic                go, accept, last;
  always_comb begin
    go      = state_q == IDLE && start_i;
    accept  = state_q == LOAD && s_valid_i && !abort_i;
    last    = accept && cnt_q == ADDR_W'(NUM_TAPS - 1);
    state_d = state_q == IDLE ? (start_i ? LOAD : IDLE)
            : state_q == LOAD ? (abort_i ? IDLE : last ? DONE : LOAD)
            : IDLE;
    // wrap the counter on the last beat so it never points past the memory
    cnt_d   = go ? '0 : accept ? (last ? '0 : cnt_q + 1'b1) : cnt_q;
    sum_d   = go ? '0 : accept ? sum_q + s_data_i : sum_q;
    we_d    = accept;
    waddr_d = accept ? cnt_q : waddr_q;
    wdata_d = accept ? s_data_i : wdata_q;
    done_d  = last;
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sum_q   <= '0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      done_q  <= done_d;
    end
  end
  assign s_ready_o  = state_q == LOAD && !abort_i;
  assign busy_o     = state_q != IDLE;
  assign we_o       = we_q;
  assign waddr_o    = waddr_q;
  assign wdata_o    = wdata_q;
  assign done_o     = done_q;
  assign checksum_o = sum_q;
endmodule
